loop_count_monitor: RTL
=======================

# loop_count_monitor

Synthesizable checker that consumes the sample stream of a bounded up-counting loop (start at 0, increment by 1, exit once the count exceeds LIMIT) and verifies it. Sits on the receiving side of a loop-counter source; reports progress, clean completion, or the first protocol violation. Used in self-checking benches and as an on-chip sanity monitor on counter buses.

## Interface
- WIDTH, 4, bit width of the observed counter
- LIMIT, 10, loop condition is count <= LIMIT; terminal sample value is LIMIT+1; legal range 0 <= LIMIT <= 2^WIDTH-2
- TIMEOUT, 16, max idle cycles allowed between valid samples while tracking (only with timeout feature)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms/re-arms the monitor
- in_valid  in  1  in_data carries a new counter sample this cycle
- in_data  in  WIDTH  observed counter value
- busy  out  1  monitor armed and tracking
- done  out  1  terminal value received with no error; held until start or rst
- err  out  1  violation detected; held until start or rst
- err_code  out  2  0 none, 1 sequence mismatch, 2 timeout, 3 wrap-around
- iter_cnt  out  WIDTH+1  count of accepted in-order samples (terminal included)
- expected  out  WIDTH  next value the monitor expects

## Operation
- States: IDLE, TRACK, DONE, FAIL.
- Reset: state IDLE; busy=0, done=0, err=0, err_code=0, iter_cnt=0, expected=0, gap counter=0.
- IDLE: in_valid ignored. start -> TRACK, expected=0, iter_cnt=0, clear done/err/err_code/gap.
- TRACK, in_valid=1:
  - in_data == expected and expected == LIMIT+1 -> DONE, iter_cnt+1.
  - in_data == expected, not terminal, expected == 2^WIDTH-1 -> FAIL, err_code=3 (unreachable for legal LIMIT; guards misconfiguration).
  - in_data == expected otherwise -> expected+1, iter_cnt+1, gap cleared.
  - in_data != expected -> FAIL, err_code=1; expected and iter_cnt frozen at values at time of failure.
- TRACK, in_valid=0: gap counter increments (timeout feature only).
- DONE / FAIL: outputs held; in_valid ignored; only start or rst leave.
- start in TRACK/DONE/FAIL: restart exactly as from IDLE; an in_valid in the same cycle as start is ignored.
- busy = (state == TRACK).
- Arithmetic: expected is WIDTH bits, increment never wraps silently (caught as code 3); iter_cnt is WIDTH+1 bits, saturates at all-ones.

## Timing
- All outputs registered; every response appears the cycle after the causing input edge.
- start at cycle N -> busy=1 at N+1; first sample accepted at N+1 earliest.
- Terminal sample at cycle N -> done=1, busy=0 at N+1.
- Mismatch at cycle N -> err=1, err_code=1, busy=0 at N+1.
- Back-to-back in_valid every cycle supported; no backpressure, no ready signal.
- rst overrides start and in_valid in the same cycle; rst mid-TRACK returns to IDLE with all reset values next cycle.

## Configuration
- LOOP_COUNT_MONITOR_TIMEOUT_EN defined: gap counter (width ceil(log2(TIMEOUT+1))) present; in TRACK, if gap reaches TIMEOUT with in_valid still low, next cycle FAIL, err_code=2. Gap counter cleared on each valid sample and on start. A valid sample arriving in the cycle gap reaches TIMEOUT is accepted (no timeout).
- Not defined: gap counter removed; TRACK waits indefinitely; err_code=2 never produced.

## Test plan
- Clean loop: rst, start, feed 0..11 one per cycle (LIMIT=10) -> done=1 one cycle after 11, iter_cnt=12, err=0, busy=0.
- Skip: start, feed 0,1,2,4 -> err=1, err_code=1 one cycle after 4, expected=3, iter_cnt=3; later samples ignored.
- Sparse: start, feed 0..11 with 3 idle cycles between samples -> done=1, iter_cnt=12; with TIMEOUT_EN and TIMEOUT=2 -> err_code=2 after 0.
- Restart: start, feed 0..5, start again (with in_valid=1, in_data=6 same cycle), feed 0..11 -> done=1, iter_cnt=12, no error.
- Reset mid-run: start, feed 0..4, assert rst one cycle -> all outputs at reset values next cycle; subsequent samples without start ignored.
- Misconfiguration: WIDTH=4, LIMIT=15, feed 0..15 -> err_code=3 one cycle after sample 15, iter_cnt=15.

Source files
------------

// File: rtl/loop_count_monitor_if.sv
// -----------------------------------------------------------------------------
// loop_count_monitor_if
//   Bundles the sample stream of a loop-counter source together with the
//   status returned by the loop_count_monitor.
//
//   Parameter:
//     WIDTH     bit width of the observed counter
//
//   Signals:
//     start     one-cycle pulse that arms or re-arms the monitor
//     in_valid  in_data carries a new counter sample this cycle
//     in_data   observed counter value
//     busy      monitor armed and tracking
//     done      terminal value received cleanly (sticky until start/rst)
//     err       violation detected (sticky until start/rst)
//     err_code  0 none, 1 sequence mismatch, 2 timeout, 3 wrap-around
//     iter_cnt  accepted in-order samples, terminal included
//     expected  next value the monitor expects
//
//   Modports:
//     master    counter source side (drives the stream, reads status)
//     slave     monitor side
// -----------------------------------------------------------------------------
interface loop_count_monitor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [WIDTH:0]   iter_cnt;
  logic [WIDTH-1:0] expected;

  modport master (
    output start, in_valid, in_data,
    input  busy, done, err, err_code, iter_cnt, expected
  );

  modport slave (
    input  start, in_valid, in_data,
    output busy, done, err, err_code, iter_cnt, expected
  );
endinterface

// File: rtl/loop_count_monitor.sv
// -----------------------------------------------------------------------------
// loop_count_monitor
//   Checks the sample stream of a bounded up-counting loop: samples must run
//   0, 1, 2, ... LIMIT+1 with no gaps. Reports progress, clean completion, or
//   the first violation, then holds the result until re-armed.
//
//   Parameters:
//     WIDTH    bit width of the observed counter
//     LIMIT    loop runs while count <= LIMIT; terminal sample is LIMIT+1
//     TIMEOUT  max idle cycles between samples while tracking
//              (used only when the timeout feature is compiled in)
//
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous, active-high reset
//     mon      loop_count_monitor_if.slave (stream in, status out)
//
//   Build option:
//     LOOP_COUNT_MONITOR_TIMEOUT_EN  when defined, a gap counter fails the
//     check with err_code 2 if the source stalls for more than TIMEOUT
//     cycles; when undefined, the monitor waits indefinitely.
// -----------------------------------------------------------------------------
module loop_count_monitor #(
  parameter int WIDTH   = 4,
  parameter int LIMIT   = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  loop_count_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_DONE,
    ST_FAIL
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SEQ     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_WRAP    = 2'd3
  } err_e;

  // Terminal value is compared one bit wider so that LIMIT+1 == 2^WIDTH
  // (a misconfigured LIMIT) never matches and falls through to the wrap check.
  localparam logic [WIDTH:0]   TERMINAL = (WIDTH+1)'(LIMIT + 1);
  localparam logic [WIDTH-1:0] EXP_MAX  = '1;
  localparam logic [WIDTH:0]   CNT_MAX  = '1;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("loop_count_monitor: TIMEOUT must be at least 1");
  end

  state_e           state_q,    state_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  err_e             err_code_q, err_code_d;
  logic [WIDTH:0]   iter_cnt_q, iter_cnt_d;
  logic [WIDTH-1:0] expected_q, expected_d;

`ifdef LOOP_COUNT_MONITOR_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a variable
    // unassigned; without these defaults synthesis would infer latches.
    state_d    = state_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    iter_cnt_d = iter_cnt_q;
    expected_d = expected_q;
`ifdef LOOP_COUNT_MONITOR_TIMEOUT_EN
    gap_d      = gap_q;
`endif

    if (mon.start) begin
      // Re-arm from any state; a sample in the same cycle is dropped.
      state_d    = ST_TRACK;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      iter_cnt_d = '0;
      expected_d = '0;
`ifdef LOOP_COUNT_MONITOR_TIMEOUT_EN
      gap_d      = '0;
`endif
    end else if (state_q == ST_TRACK) begin
      if (mon.in_valid) begin
        if (mon.in_data == expected_q) begin
          if ({1'b0, expected_q} == TERMINAL) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            iter_cnt_d = (iter_cnt_q == CNT_MAX) ? iter_cnt_q : iter_cnt_q + 1'b1;
          end else if (expected_q == EXP_MAX) begin
            // In-order but the next expected value cannot be represented.
            state_d    = ST_FAIL;
            err_d      = 1'b1;
            err_code_d = ERR_WRAP;
          end else begin
            expected_d = expected_q + 1'b1;
            iter_cnt_d = (iter_cnt_q == CNT_MAX) ? iter_cnt_q : iter_cnt_q + 1'b1;
`ifdef LOOP_COUNT_MONITOR_TIMEOUT_EN
            gap_d      = '0;
`endif
          end
        end else begin
          // expected/iter_cnt stay frozen at the point of failure.
          state_d    = ST_FAIL;
          err_d      = 1'b1;
          err_code_d = ERR_SEQ;
        end
      end else begin
`ifdef LOOP_COUNT_MONITOR_TIMEOUT_EN
        // A sample arriving while gap == TIMEOUT is still accepted above;
        // only a further idle cycle trips the timeout.
        if (gap_q == GAP_LIMIT) begin
          state_d    = ST_FAIL;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
`endif
      end
    end

    busy_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      iter_cnt_q <= '0;
      expected_q <= '0;
`ifdef LOOP_COUNT_MONITOR_TIMEOUT_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      iter_cnt_q <= iter_cnt_d;
      expected_q <= expected_d;
`ifdef LOOP_COUNT_MONITOR_TIMEOUT_EN
      gap_q      <= gap_d;
`endif
    end
  end

  assign mon.busy     = busy_q;
  assign mon.done     = done_q;
  assign mon.err      = err_q;
  assign mon.err_code = err_code_q;
  assign mon.iter_cnt = iter_cnt_q;
  assign mon.expected = expected_q;

endmodule
